// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-port data memory between an instruction-fetch requester
// (port 0) and a load/store requester (port 1). One request is accepted at a
// time under round-robin priority. The memory is driven for exactly one cycle
// (ACCESS), and the result is returned one cycle later (RESPOND). A handshake
// in cycle N gives a memory access in N+1 and a response in N+2.
//
// Ports:
//   clk, rst                     clock and synchronous active-high reset
//   reqN_valid/write/addr/wdata  request fields from requester N
//   reqN_ready                   request accepted this cycle (combinational)
//   respN_valid                  one-cycle response pulse to requester N
//   respN_rdata                  load data, zero unless respN_valid
//   respN_err                    misaligned-address error, zero unless respN_valid
//   mem_address/write_data       address and store data to the memory
//   mem_write/mem_read           memory enables, asserted only in ACCESS
//   mem_data                     read data from the memory, valid in RESPOND
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  req0_valid,
    input  logic                  req0_write,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_wdata,
    output logic                  req0_ready,
    output logic                  resp0_valid,
    output logic [DATA_WIDTH-1:0] resp0_rdata,
    output logic                  resp0_err,

    input  logic                  req1_valid,
    input  logic                  req1_write,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_wdata,
    output logic                  req1_ready,
    output logic                  resp1_valid,
    output logic [DATA_WIDTH-1:0] resp1_rdata,
    output logic                  resp1_err,

    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_write_data,
    output logic                  mem_write,
    output logic                  mem_read,
    input  logic [DATA_WIDTH-1:0] mem_data
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ACCESS  = 2'd1,
        S_RESPOND = 2'd2
    } state_t;

    // A word access needs the two low address bits clear.
    function automatic logic is_misaligned(input logic [1:0] low_bits);
        return (low_bits != 2'b00);
    endfunction

    state_t                r_state;
    logic                  r_last_grant;
    logic                  r_port;
    logic                  r_write;
    logic                  r_misalign;
    logic                  r_rd_ok;
    logic [ADDR_WIDTH-1:0] r_mem_address;
    logic [DATA_WIDTH-1:0] r_mem_write_data;
    logic                  r_mem_write;
    logic                  r_mem_read;
    logic                  r_resp0_valid;
    logic                  r_resp1_valid;
    logic                  r_resp0_err;
    logic                  r_resp1_err;

    logic                  w_grant0;
    logic                  w_grant1;
    logic                  w_ready0;
    logic                  w_ready1;
    logic                  w_sel_write;
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic [DATA_WIDTH-1:0] w_sel_wdata;
    logic                  w_sel_misalign;

    // Round-robin arbitration: on a tie the port not granted last time wins.
    always_comb begin
        w_grant0 = 1'b0;
        w_grant1 = 1'b0;
        if (req0_valid && req1_valid) begin
            if (r_last_grant == 1'b0) begin
                w_grant1 = 1'b1;
            end else begin
                w_grant0 = 1'b1;
            end
        end else if (req0_valid) begin
            w_grant0 = 1'b1;
        end else if (req1_valid) begin
            w_grant1 = 1'b1;
        end else begin
            w_grant0 = 1'b0;
            w_grant1 = 1'b0;
        end
    end

    // Ready only in IDLE and never while reset is asserted.
    always_comb begin
        w_ready0 = 1'b0;
        w_ready1 = 1'b0;
        if ((r_state == S_IDLE) && !rst) begin
            w_ready0 = w_grant0;
            w_ready1 = w_grant1;
        end else begin
            w_ready0 = 1'b0;
            w_ready1 = 1'b0;
        end
    end

    // Mux the fields of the granted port toward the request latch.
    always_comb begin
        w_sel_write = 1'b0;
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        if (w_grant1) begin
            w_sel_write = req1_write;
            w_sel_addr  = req1_addr;
            w_sel_wdata = req1_wdata;
        end else begin
            w_sel_write = req0_write;
            w_sel_addr  = req0_addr;
            w_sel_wdata = req0_wdata;
        end
        w_sel_misalign = is_misaligned(w_sel_addr[1:0]);
    end

    // Main FSM: latches the request, drives memory for one cycle, then responds.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state          <= S_IDLE;
            r_last_grant     <= 1'b1;
            r_port           <= 1'b0;
            r_write          <= 1'b0;
            r_misalign       <= 1'b0;
            r_rd_ok          <= 1'b0;
            r_mem_address    <= '0;
            r_mem_write_data <= '0;
            r_mem_write      <= 1'b0;
            r_mem_read       <= 1'b0;
            r_resp0_valid    <= 1'b0;
            r_resp1_valid    <= 1'b0;
            r_resp0_err      <= 1'b0;
            r_resp1_err      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_ready0 || w_ready1) begin
                        r_state          <= S_ACCESS;
                        r_last_grant     <= w_grant1;
                        r_port           <= w_grant1;
                        r_write          <= w_sel_write;
                        r_misalign       <= w_sel_misalign;
                        r_mem_address    <= w_sel_addr;
                        r_mem_write_data <= w_sel_wdata;
                        // Misaligned requests never touch the memory.
                        r_mem_write      <= w_sel_write & ~w_sel_misalign;
                        r_mem_read       <= ~w_sel_write & ~w_sel_misalign;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_ACCESS: begin
                    r_state       <= S_RESPOND;
                    r_mem_address <= '0;
                    r_mem_write   <= 1'b0;
                    r_mem_read    <= 1'b0;
                    r_resp0_valid <= ~r_port;
                    r_resp1_valid <= r_port;
                    r_resp0_err   <= ~r_port & r_misalign;
                    r_resp1_err   <= r_port & r_misalign;
                    // Only an aligned load forwards memory data.
                    r_rd_ok       <= ~r_write & ~r_misalign;
                end
                S_RESPOND: begin
                    r_state       <= S_IDLE;
                    r_resp0_valid <= 1'b0;
                    r_resp1_valid <= 1'b0;
                    r_resp0_err   <= 1'b0;
                    r_resp1_err   <= 1'b0;
                    r_rd_ok       <= 1'b0;
                end
                default: begin
                    r_state       <= S_IDLE;
                    r_mem_address <= '0;
                    r_mem_write   <= 1'b0;
                    r_mem_read    <= 1'b0;
                    r_resp0_valid <= 1'b0;
                    r_resp1_valid <= 1'b0;
                    r_resp0_err   <= 1'b0;
                    r_resp1_err   <= 1'b0;
                    r_rd_ok       <= 1'b0;
                end
            endcase
        end
    end

    assign req0_ready     = w_ready0;
    assign req1_ready     = w_ready1;
    assign mem_address    = r_mem_address;
    assign mem_write_data = r_mem_write_data;
    assign mem_write      = r_mem_write;
    assign mem_read       = r_mem_read;
    assign resp0_valid    = r_resp0_valid;
    assign resp1_valid    = r_resp1_valid;
    assign resp0_err      = r_resp0_err;
    assign resp1_err      = r_resp1_err;
    // The memory returns read data in the cycle after the access, so the
    // response forwards mem_data directly, gated by registered qualifiers.
    assign resp0_rdata    = (r_resp0_valid && r_rd_ok) ? mem_data : '0;
    assign resp1_rdata    = (r_resp1_valid && r_rd_ok) ? mem_data : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Directed testbench for mem_port_arbiter. A small synchronous-read memory
// model sits on the memory side. Inputs change on the falling edge and
// outputs are sampled 1 time unit later, away from the rising edge.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst;
    logic        req0_valid;
    logic        req0_write;
    logic [31:0] req0_addr;
    logic [31:0] req0_wdata;
    logic        req0_ready;
    logic        resp0_valid;
    logic [31:0] resp0_rdata;
    logic        resp0_err;
    logic        req1_valid;
    logic        req1_write;
    logic [31:0] req1_addr;
    logic [31:0] req1_wdata;
    logic        req1_ready;
    logic        resp1_valid;
    logic [31:0] resp1_rdata;
    logic        resp1_err;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic        mem_write;
    logic        mem_read;
    logic [31:0] mem_data;

    int n_checks;
    int n_fail;

    logic [31:0] tb_mem [0:15];
    logic [31:0] mem_data_r;

    mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .req0_valid     (req0_valid),
        .req0_write     (req0_write),
        .req0_addr      (req0_addr),
        .req0_wdata     (req0_wdata),
        .req0_ready     (req0_ready),
        .resp0_valid    (resp0_valid),
        .resp0_rdata    (resp0_rdata),
        .resp0_err      (resp0_err),
        .req1_valid     (req1_valid),
        .req1_write     (req1_write),
        .req1_addr      (req1_addr),
        .req1_wdata     (req1_wdata),
        .req1_ready     (req1_ready),
        .resp1_valid    (resp1_valid),
        .resp1_rdata    (resp1_rdata),
        .resp1_err      (resp1_err),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_write      (mem_write),
        .mem_read       (mem_read),
        .mem_data       (mem_data)
    );

    always #5 clk = ~clk;

    // Synchronous memory: writes and reads happen on the edge ending ACCESS.
    always @(posedge clk) begin
        if (mem_write) tb_mem[mem_address[5:2]] <= mem_write_data;
        if (mem_read)  mem_data_r <= tb_mem[mem_address[5:2]];
    end
    assign mem_data = mem_data_r;

    task automatic drive_port(input int p, input logic v, input logic w,
                              input logic [31:0] a, input logic [31:0] d);
        if (p == 0) begin
            req0_valid = v; req0_write = w; req0_addr = a; req0_wdata = d;
        end else begin
            req1_valid = v; req1_write = w; req1_addr = a; req1_wdata = d;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        drive_port(0, 1'b1, 1'b0, 32'h0, 32'h0);
        drive_port(1, 1'b1, 1'b0, 32'h4, 32'h0);
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); #1;
            n_checks++; if (req0_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready0: got %b want 0", req0_ready); end
            n_checks++; if (req1_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready1: got %b want 0", req1_ready); end
            n_checks++; if (resp0_valid !== 1'b0 || resp1_valid !== 1'b0) begin n_fail++; $display("FAIL rst_resp: got %b%b want 00", resp0_valid, resp1_valid); end
            n_checks++; if (mem_write !== 1'b0 || mem_read !== 1'b0) begin n_fail++; $display("FAIL rst_mem_en: got w=%b r=%b want 0", mem_write, mem_read); end
            n_checks++; if (mem_address !== 32'h0) begin n_fail++; $display("FAIL rst_mem_addr: got %h want 0", mem_address); end
        end
        rst = 1'b0; #1;
        n_checks++; if (req0_ready !== 1'b1) begin n_fail++; $display("FAIL rst_first_tie_rdy0: got %b want 1", req0_ready); end
        n_checks++; if (req1_ready !== 1'b0) begin n_fail++; $display("FAIL rst_first_tie_rdy1: got %b want 0", req1_ready); end
        req0_valid = 1'b0; req1_valid = 1'b0;
    endtask

    task automatic test_store_load_p1;
        @(negedge clk); drive_port(1, 1'b1, 1'b1, 32'h4, 32'h5555_5555); #1;
        n_checks++; if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin n_fail++; $display("FAIL st1_ready: got r0=%b r1=%b want r0=0 r1=1", req0_ready, req1_ready); end
        @(negedge clk); req1_valid = 1'b0; #1;
        n_checks++; if (mem_write !== 1'b1 || mem_read !== 1'b0) begin n_fail++; $display("FAIL st1_access_en: got w=%b r=%b want w=1 r=0", mem_write, mem_read); end
        n_checks++; if (mem_address !== 32'h4) begin n_fail++; $display("FAIL st1_access_addr: got %h want 4", mem_address); end
        n_checks++; if (mem_write_data !== 32'h5555_5555) begin n_fail++; $display("FAIL st1_access_wdata: got %h want 55555555", mem_write_data); end
        n_checks++; if (resp1_valid !== 1'b0) begin n_fail++; $display("FAIL st1_early_resp: got %b want 0", resp1_valid); end
        @(negedge clk); #1;
        n_checks++; if (resp1_valid !== 1'b1 || resp1_err !== 1'b0 || resp1_rdata !== 32'h0) begin n_fail++; $display("FAIL st1_resp: got v=%b e=%b d=%h want v=1 e=0 d=0", resp1_valid, resp1_err, resp1_rdata); end
        n_checks++; if (resp0_valid !== 1'b0) begin n_fail++; $display("FAIL st1_resp0_quiet: got %b want 0", resp0_valid); end
        n_checks++; if (mem_write !== 1'b0 || mem_address !== 32'h0) begin n_fail++; $display("FAIL st1_respond_mem_idle: got w=%b a=%h want 0", mem_write, mem_address); end
        @(negedge clk); drive_port(1, 1'b1, 1'b0, 32'h4, 32'h0); #1;
        n_checks++; if (req1_ready !== 1'b1) begin n_fail++; $display("FAIL ld1_ready: got %b want 1", req1_ready); end
        @(negedge clk); req1_valid = 1'b0; #1;
        n_checks++; if (mem_read !== 1'b1 || mem_write !== 1'b0) begin n_fail++; $display("FAIL ld1_access_en: got w=%b r=%b want w=0 r=1", mem_write, mem_read); end
        @(negedge clk); #1;
        n_checks++; if (resp1_valid !== 1'b1 || resp1_rdata !== 32'h5555_5555) begin n_fail++; $display("FAIL ld1_resp: got v=%b d=%h want v=1 d=55555555", resp1_valid, resp1_rdata); end
    endtask

    task automatic test_tie_rr;
        logic [31:0] exp_data;
        logic [31:0] exp_addr;
        logic        exp0;
        @(negedge clk);
        drive_port(0, 1'b1, 1'b0, 32'h0, 32'h0);
        drive_port(1, 1'b1, 1'b0, 32'h4, 32'h0);
        #1;
        for (int k = 0; k < 4; k++) begin
            exp0     = ((k % 2) == 0);
            exp_addr = exp0 ? 32'h0 : 32'h4;
            exp_data = exp0 ? 32'hA0A0_0000 : 32'h5555_5555;
            if (k > 0) begin @(negedge clk); #1; end
            n_checks++; if (req0_ready !== exp0 || req1_ready !== ~exp0) begin n_fail++; $display("FAIL rr_grant[%0d]: got r0=%b r1=%b want r0=%b", k, req0_ready, req1_ready, exp0); end
            @(negedge clk); #1;
            n_checks++; if (mem_read !== 1'b1 || mem_address !== exp_addr) begin n_fail++; $display("FAIL rr_access[%0d]: got r=%b a=%h want r=1 a=%h", k, mem_read, mem_address, exp_addr); end
            n_checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin n_fail++; $display("FAIL rr_busy_ready[%0d]: got %b%b want 00", k, req0_ready, req1_ready); end
            @(negedge clk); #1;
            n_checks++; if (resp0_valid !== exp0 || resp1_valid !== ~exp0) begin n_fail++; $display("FAIL rr_resp_port[%0d]: got v0=%b v1=%b want v0=%b", k, resp0_valid, resp1_valid, exp0); end
            n_checks++; if ((exp0 ? resp0_rdata : resp1_rdata) !== exp_data) begin n_fail++; $display("FAIL rr_resp_data[%0d]: got %h want %h", k, exp0 ? resp0_rdata : resp1_rdata, exp_data); end
            n_checks++; if ((exp0 ? resp1_rdata : resp0_rdata) !== 32'h0) begin n_fail++; $display("FAIL rr_other_rdata[%0d]: got %h want 0", k, exp0 ? resp1_rdata : resp0_rdata); end
        end
        @(negedge clk); req0_valid = 1'b0; req1_valid = 1'b0;
    endtask

    task automatic test_misaligned;
        @(negedge clk); drive_port(0, 1'b1, 1'b1, 32'h6, 32'hDEAD_BEEF); #1;
        n_checks++; if (req0_ready !== 1'b1 || mem_write !== 1'b0) begin n_fail++; $display("FAIL mis_idle: got rdy=%b w=%b want rdy=1 w=0", req0_ready, mem_write); end
        @(negedge clk); req0_valid = 1'b0; #1;
        n_checks++; if (mem_write !== 1'b0 || mem_read !== 1'b0) begin n_fail++; $display("FAIL mis_access_en: got w=%b r=%b want 0", mem_write, mem_read); end
        @(negedge clk); #1;
        n_checks++; if (resp0_valid !== 1'b1 || resp0_err !== 1'b1 || resp0_rdata !== 32'h0) begin n_fail++; $display("FAIL mis_resp: got v=%b e=%b d=%h want v=1 e=1 d=0", resp0_valid, resp0_err, resp0_rdata); end
        n_checks++; if (mem_write !== 1'b0 || resp1_err !== 1'b0) begin n_fail++; $display("FAIL mis_respond_side: got w=%b e1=%b want 0", mem_write, resp1_err); end
        @(negedge clk); drive_port(0, 1'b1, 1'b0, 32'h4, 32'h0); #1;
        n_checks++; if (req0_ready !== 1'b1) begin n_fail++; $display("FAIL mis_ld_ready: got %b want 1", req0_ready); end
        @(negedge clk); req0_valid = 1'b0; #1;
        n_checks++; if (mem_read !== 1'b1 || mem_address !== 32'h4) begin n_fail++; $display("FAIL mis_ld_access: got r=%b a=%h want r=1 a=4", mem_read, mem_address); end
        @(negedge clk); #1;
        n_checks++; if (resp0_rdata !== 32'h5555_5555 || resp0_err !== 1'b0) begin n_fail++; $display("FAIL mis_ld_unchanged: got d=%h e=%b want d=55555555 e=0", resp0_rdata, resp0_err); end
    endtask

    task automatic test_reset_midop;
        @(negedge clk); drive_port(0, 1'b1, 1'b1, 32'h8, 32'h1234_5678); #1;
        n_checks++; if (req0_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_ready: got %b want 1", req0_ready); end
        @(negedge clk); drive_port(0, 1'b1, 1'b0, 32'h0, 32'h0); #1;
        n_checks++; if (mem_write !== 1'b1 || mem_address !== 32'h8) begin n_fail++; $display("FAIL rmid_access: got w=%b a=%h want w=1 a=8", mem_write, mem_address); end
        rst = 1'b1;
        @(negedge clk); #1;
        n_checks++; if (resp0_valid !== 1'b0 || resp0_err !== 1'b0) begin n_fail++; $display("FAIL rmid_no_resp: got v=%b e=%b want 0", resp0_valid, resp0_err); end
        n_checks++; if (mem_write !== 1'b0 || mem_read !== 1'b0 || mem_address !== 32'h0) begin n_fail++; $display("FAIL rmid_mem_clear: got w=%b r=%b a=%h want 0", mem_write, mem_read, mem_address); end
        n_checks++; if (req0_ready !== 1'b0) begin n_fail++; $display("FAIL rmid_ready_in_rst: got %b want 0", req0_ready); end
        rst = 1'b0; req0_valid = 1'b0;
        @(negedge clk); #1;
        n_checks++; if (resp0_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_late_resp: got %b want 0", resp0_valid); end
        drive_port(1, 1'b1, 1'b0, 32'h4, 32'h0); #1;
        n_checks++; if (req1_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_next_ready: got %b want 1", req1_ready); end
        @(negedge clk); req1_valid = 1'b0;
        @(negedge clk); #1;
        n_checks++; if (resp1_valid !== 1'b1 || resp1_rdata !== 32'h5555_5555) begin n_fail++; $display("FAIL rmid_next_resp: got v=%b d=%h want v=1 d=55555555", resp1_valid, resp1_rdata); end
    endtask

    task automatic test_backpressure;
        @(negedge clk);
        drive_port(0, 1'b1, 1'b0, 32'h4, 32'h0);
        drive_port(1, 1'b1, 1'b1, 32'hC, 32'hCAFE_F00D);
        #1;
        n_checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin n_fail++; $display("FAIL bp_idle: got r0=%b r1=%b want r0=1 r1=0", req0_ready, req1_ready); end
        @(negedge clk); req0_valid = 1'b0; #1;
        n_checks++; if (req1_ready !== 1'b0 || mem_read !== 1'b1 || mem_address !== 32'h4) begin n_fail++; $display("FAIL bp_access: got r1=%b rd=%b a=%h want r1=0 rd=1 a=4", req1_ready, mem_read, mem_address); end
        @(negedge clk); #1;
        n_checks++; if (req1_ready !== 1'b0 || resp0_valid !== 1'b1 || resp0_rdata !== 32'h5555_5555) begin n_fail++; $display("FAIL bp_respond: got r1=%b v0=%b d=%h want r1=0 v0=1 d=55555555", req1_ready, resp0_valid, resp0_rdata); end
        @(negedge clk); #1;
        n_checks++; if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin n_fail++; $display("FAIL bp_next_idle: got r0=%b r1=%b want r0=0 r1=1", req0_ready, req1_ready); end
        @(negedge clk); req1_valid = 1'b0; #1;
        n_checks++; if (mem_write !== 1'b1 || mem_address !== 32'hC || mem_write_data !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL bp_st_access: got w=%b a=%h d=%h want w=1 a=c d=cafef00d", mem_write, mem_address, mem_write_data); end
        @(negedge clk); #1;
        n_checks++; if (resp1_valid !== 1'b1 || resp1_err !== 1'b0) begin n_fail++; $display("FAIL bp_st_resp: got v=%b e=%b want v=1 e=0", resp1_valid, resp1_err); end
        @(negedge clk); drive_port(0, 1'b1, 1'b0, 32'hC, 32'h0);
        @(negedge clk); req0_valid = 1'b0;
        @(negedge clk); #1;
        n_checks++; if (resp0_valid !== 1'b1 || resp0_rdata !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL bp_readback: got v=%b d=%h want v=1 d=cafef00d", resp0_valid, resp0_rdata); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        clk      = 1'b0;
        rst      = 1'b1;
        mem_data_r = 32'h0;
        for (int i = 0; i < 16; i++) tb_mem[i] = 32'h0;
        tb_mem[0] = 32'hA0A0_0000;
        tb_mem[1] = 32'h1111_1111;
        tb_mem[2] = 32'h2222_2222;
        drive_port(0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive_port(1, 1'b0, 1'b0, 32'h0, 32'h0);

        test_reset;
        test_store_load_p1;
        test_tie_rr;
        test_misaligned;
        test_reset_midop;
        test_backpressure;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
